// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back select plus 32x DATA_W register file with write-through read ports
// Ports: clk/rst (async active-high); ALUResult, ReadDataDM, MemToReg select WriteData;
// RegWrite/WriteRegister commit it; ReadRegister1/2 -> ReadData1/2 (combinational, bypassed);
// WriteCount counts committed writes (registered, wraps).
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] ReadDataDM,
   input  logic              MemToReg,
   input  logic              RegWrite,
   input  logic [4:0]        WriteRegister,
   input  logic [4:0]        ReadRegister1,
   input  logic [4:0]        ReadRegister2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] WriteData,
   output logic [CNT_W-1:0]  WriteCount
);
   logic [DATA_W-1:0] regs_q [32];
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we;
   assign WriteData  = MemToReg ? ReadDataDM : ALUResult;
   assign we         = RegWrite && (WriteRegister != 5'd0);
   assign cnt_d      = cnt_q + 1'b1;
   assign WriteCount = cnt_q;
   // index 0 is never written, so regs_q[0] stays 0; the explicit zero test also blocks bypass to r0
   assign ReadData1 = (ReadRegister1 == 5'd0) ? '0 :
                      (we && WriteRegister == ReadRegister1) ? WriteData : regs_q[ReadRegister1];
   assign ReadData2 = (ReadRegister2 == 5'd0) ? '0 :
                      (we && WriteRegister == ReadRegister2) ? WriteData : regs_q[ReadRegister2];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
         cnt_q <= '0;
      end else if (we) begin
         regs_q[WriteRegister] <= WriteData;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile (32-bit counter and 4-bit counter instances)
module tb_wb_regfile;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResult, ReadDataDM;
   logic        MemToReg, RegWrite;
   logic [4:0]  WriteRegister, ReadRegister1, ReadRegister2;
   logic [31:0] ReadData1, ReadData2, WriteData, WriteCount;
   logic [31:0] ReadData1_s, ReadData2_s, WriteData_s;
   logic [3:0]  WriteCount_s;
   int          n_checks = 0;
   int          n_fail = 0;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;
   chk_t q[$];

   always #5 clk = ~clk;

   wb_regfile #(.DATA_W(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .ALUResult(ALUResult), .ReadDataDM(ReadDataDM),
      .MemToReg(MemToReg), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteData(WriteData),
      .WriteCount(WriteCount)
   );

   wb_regfile #(.DATA_W(32), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .ALUResult(ALUResult), .ReadDataDM(ReadDataDM),
      .MemToReg(MemToReg), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(ReadData1_s), .ReadData2(ReadData2_s), .WriteData(WriteData_s),
      .WriteCount(WriteCount_s)
   );

   // monitor: outputs are stable at the falling edge; drain every pending expectation
   always @(negedge clk) begin
      while (q.size() > 0) begin
         chk_t c;
         logic [31:0] act;
         c = q.pop_front();
         case (c.sel)
            0:       act = ReadData1;
            1:       act = ReadData2;
            2:       act = WriteData;
            3:       act = WriteCount;
            default: act = {28'd0, WriteCount_s};
         endcase
         n_checks++;
         if (act !== c.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
         end
      end
   end

   task automatic expect_v(input string name, input int sel, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      q.push_back(c);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] v);
      RegWrite = 1'b1; MemToReg = 1'b0; ALUResult = v; WriteRegister = r;
   endtask

   initial begin
      rst = 1'b1; ALUResult = '0; ReadDataDM = '0; MemToReg = 1'b0; RegWrite = 1'b0;
      WriteRegister = '0; ReadRegister1 = 5'd5; ReadRegister2 = 5'd8;
      step(); step();
      rst = 1'b0;
      expect_v("reset_rd1", 0, 32'h0);
      expect_v("reset_rd2", 1, 32'h0);
      expect_v("reset_wc", 3, 32'h0);
      step();
      // r5 = DEADBEEF, then asynchronous reset mid-run
      wr(5'd5, 32'hDEADBEEF);
      expect_v("r5_bypass", 0, 32'hDEADBEEF);
      step();
      RegWrite = 1'b0;
      expect_v("r5_stored", 0, 32'hDEADBEEF);
      expect_v("r5_wc", 3, 32'd1);
      step();
      rst = 1'b1;
      expect_v("rst_async_rd1", 0, 32'h0);
      expect_v("rst_async_wc", 3, 32'h0);
      expect_v("rst_async_wcs", 4, 32'h0);
      @(negedge clk); #1;
      wr(5'd5, 32'h1);
      step();
      rst = 1'b0; RegWrite = 1'b0;
      expect_v("rst_lost_write_rd1", 0, 32'h0);
      expect_v("rst_lost_write_wc", 3, 32'h0);
      step();
      // ALU write-back
      RegWrite = 1'b1; MemToReg = 1'b0; ALUResult = 32'h11; ReadDataDM = 32'h55;
      WriteRegister = 5'd8; ReadRegister1 = 5'd8;
      expect_v("alu_wd", 2, 32'h11);
      step();
      RegWrite = 1'b0;
      expect_v("alu_r8", 0, 32'h11);
      expect_v("alu_wc", 3, 32'd1);
      expect_v("alu_wcs", 4, 32'd1);
      step();
      // load write-back with bypass on both ports
      RegWrite = 1'b1; MemToReg = 1'b1; ReadDataDM = 32'hCAFEF00D;
      WriteRegister = 5'd9; ReadRegister1 = 5'd9; ReadRegister2 = 5'd9;
      expect_v("ld_bypass_rd1", 0, 32'hCAFEF00D);
      expect_v("ld_bypass_rd2", 1, 32'hCAFEF00D);
      expect_v("ld_wd", 2, 32'hCAFEF00D);
      step();
      RegWrite = 1'b0; MemToReg = 1'b0;
      expect_v("ld_r9_rd1", 0, 32'hCAFEF00D);
      expect_v("ld_r9_rd2", 1, 32'hCAFEF00D);
      expect_v("ld_wc", 3, 32'd2);
      step();
      // r0 protection
      wr(5'd0, 32'hFFFFFFFF);
      ReadRegister1 = 5'd0;
      expect_v("r0_before", 0, 32'h0);
      expect_v("r0_wd", 2, 32'hFFFFFFFF);
      expect_v("r0_r9_unaffected", 1, 32'hCAFEF00D);
      step();
      RegWrite = 1'b0;
      expect_v("r0_after", 0, 32'h0);
      expect_v("r0_wc", 3, 32'd2);
      step();
      // disabled write
      wr(5'd3, 32'h77);
      step();
      RegWrite = 1'b0; ALUResult = 32'h1234; ReadRegister1 = 5'd3;
      expect_v("dis_rd1", 0, 32'h77);
      expect_v("dis_wd", 2, 32'h1234);
      expect_v("dis_wc", 3, 32'd3);
      step();
      expect_v("dis_r3_held", 0, 32'h77);
      expect_v("dis_wc_held", 3, 32'd3);
      step();
      // counter wrap on the 4-bit instance: 3 + 16 writes, passes 15 -> 0
      for (int i = 0; i < 16; i++) begin
         wr(5'd10, i);
         step();
         RegWrite = 1'b0;
         expect_v("wrap_wcs", 4, (3 + i + 1) % 16);
         expect_v("wrap_wc", 3, 3 + i + 1);
         step();
      end
      ReadRegister2 = 5'd10;
      expect_v("wrap_r10", 1, 32'd15);
      // back-to-back writes to r4
      wr(5'd4, 32'hA);
      ReadRegister1 = 5'd4;
      step();
      ALUResult = 32'hB;
      expect_v("b2b_bypass", 0, 32'hB);
      step();
      RegWrite = 1'b0;
      expect_v("b2b_r4", 0, 32'hB);
      expect_v("b2b_wc", 3, 32'd21);
      expect_v("b2b_wcs", 4, 32'd5);
      step();
      step();
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, 0 required", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage pipelined MIPS core. It consumes the MEM/WB pipeline register outputs and selects the write-back value: data memory read data or ALU result. It commits that value to a 32-entry register file and serves the two decode-stage read ports. Read ports have write-through bypass, so an instruction in ID sees a value being written back in the same cycle.

## Interface
Parameters:
- DATA_W, 32, register and data width
- CNT_W, 32, width of the write-commit counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- ALUResult  input  DATA_W  ALU result from MEM/WB
- ReadDataDM  input  DATA_W  data-memory read data from MEM/WB
- MemToReg  input  1  1 = write back ReadDataDM, 0 = write back ALUResult
- RegWrite  input  1  write-back enable from MEM/WB
- WriteRegister  input  5  destination register index
- ReadRegister1  input  5  ID-stage source index rs
- ReadRegister2  input  5  ID-stage source index rt
- ReadData1  output  DATA_W  value of ReadRegister1, combinational
- ReadData2  output  DATA_W  value of ReadRegister2, combinational
- WriteData  output  DATA_W  selected write-back value, combinational; also feeds EX forwarding
- WriteCount  output  CNT_W  number of committed register writes, registered

## Operation
- WriteData = MemToReg ? ReadDataDM : ALUResult. It is computed regardless of RegWrite.
- Effective write: we = RegWrite && (WriteRegister != 0).
- On a rising clk edge with we, regs[WriteRegister] <= WriteData. Otherwise all registers hold.
- Register 0 is hardwired to 0:
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0, with no bypass.
- Read port n (n = 1, 2):
  - If ReadRegister_n == 0, ReadData_n = 0.
  - Else if we && WriteRegister == ReadRegister_n, ReadData_n = WriteData (bypass).
  - Else ReadData_n = regs[ReadRegister_n].
- Both ports may address the same register, including the one being written; both then return the bypassed value.
- WriteCount increments by 1 on each rising edge where we = 1.
  - It wraps from 2^CNT_W-1 to 0.
  - It does not count writes to index 0 or cycles with RegWrite = 0.
- Reset, asserted at any time including mid-write:
  - All 32 registers and WriteCount go to 0 immediately.
  - A write whose edge coincides with rst asserted is lost.
- Inputs with X on RegWrite are a protocol violation. The MEM/WB register guarantees 0 out of reset.

## Timing
- Reset values: regs[0..31] = 0; WriteCount = 0.
- ReadData1/2 and WriteData are combinational outputs of the current state and inputs. After reset with no write pending, ReadData1 = ReadData2 = 0.
- Write latency: one edge. The value is visible from regs on the cycle after the edge, and via bypass in the same cycle.
- WriteCount reflects a write one cycle after the committing edge.
- No handshake. Every cycle with we = 1 commits unconditionally; the pipeline never stalls WB.
- Back-to-back writes to the same index on consecutive cycles: the last write wins. The bypass always shows the current cycle's WriteData.
- Release of rst is asynchronous. The first commit is taken on the first rising edge with rst low.

## Test plan
- Reset: assert rst mid-run after writing 0xDEADBEEF to r5, then release.
  - Required: ReadData1 for r5 = 0 and WriteCount = 0, both immediately on assertion.
- ALU write-back: RegWrite=1, MemToReg=0, ALUResult=0x00000011, ReadDataDM=0x55, WriteRegister=8.
  - Required: after the edge, reading r8 gives 0x00000011 and WriteCount = 1.
- Load write-back with same-cycle bypass: MemToReg=1, ReadDataDM=0xCAFEF00D, WriteRegister=9, ReadRegister1=9, ReadRegister2=9.
  - Required: both read ports show 0xCAFEF00D before the edge, and regs[9] holds it after.
- r0 protection: RegWrite=1, WriteRegister=0, ALUResult=0xFFFFFFFF, ReadRegister1=0.
  - Required: ReadData1 = 0 before and after the edge, and WriteCount is unchanged.
- Disabled write: RegWrite=0, WriteRegister=3, ALUResult=0x1234, with r3 previously 0x77.
  - Required: ReadData for r3 = 0x77 (no bypass), r3 is unchanged, and WriteData still = 0x1234.
- Counter wrap: with CNT_W=4, perform 16 valid writes.
  - Required: WriteCount goes 15 -> 0. Two consecutive writes to r4 (0xA, then 0xB) leave r4 = 0xB.
